// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU request arbiter: FSM state encoding,
// ALU opcodes and a constant-foldable clog2 helper.
package alu_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAKE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } arb_state_e;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OP_W-1:0] OP_MUL   = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [OP_W-1:0] OP_AND   = 4'd4;
  localparam logic [OP_W-1:0] OP_OR    = 4'd5;
  localparam logic [OP_W-1:0] OP_NAND  = 4'd6;
  localparam logic [OP_W-1:0] OP_NOR   = 4'd7;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd8;
  localparam logic [OP_W-1:0] OP_XNOR  = 4'd9;
  localparam logic [OP_W-1:0] OP_CMPEQ = 4'd10;
  localparam logic [OP_W-1:0] OP_CMPGT = 4'd11;
  localparam logic [OP_W-1:0] OP_CMPLT = 4'd12;
  localparam logic [OP_W-1:0] OP_SHR   = 4'd13;
  localparam logic [OP_W-1:0] OP_SHL   = 4'd14;

  // Smallest r with 2**r >= n (0 for n <= 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the
// pointer, searching cyclically. Produces one-hot grant and its index.
module rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  int unsigned    pos;
  logic [IDW-1:0] pos_idx;
  logic           found;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(ptr_i) + k;
      if (pos >= N) pos = pos - N;
      pos_idx = IDW'(pos);
      if (!found && req_i[pos_idx]) begin
        found          = 1'b1;
        gnt_o[pos_idx] = 1'b1;
        idx_o          = pos_idx;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one registered ALU among NUM_REQ requesters: round-robin grant,
// single-cycle alu_en, result return with timeout, and idle clock gating.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned DATA_IN_WIDTH    = 8,
  parameter int unsigned OP_CODE_WIDTH    = 4,
  parameter int unsigned GATE_IDLE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES   = 8
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*DATA_IN_WIDTH-1:0]    req_a,
  input  logic [NUM_REQ*DATA_IN_WIDTH-1:0]    req_b,
  input  logic [NUM_REQ*OP_CODE_WIDTH-1:0]    req_fun,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [2*DATA_IN_WIDTH-1:0]          rsp_data,
  output logic                                rsp_err,
  output logic                                alu_en,
  output logic [DATA_IN_WIDTH-1:0]            alu_a,
  output logic [DATA_IN_WIDTH-1:0]            alu_b,
  output logic [OP_CODE_WIDTH-1:0]            alu_fun,
  input  logic [2*DATA_IN_WIDTH-1:0]          alu_out,
  input  logic                                alu_out_valid,
  output logic                                alu_clk_en
);

  localparam int unsigned DATA_OUT_WIDTH = 2 * DATA_IN_WIDTH;
  localparam int unsigned IDW            = clog2(NUM_REQ);
  localparam int unsigned GCW            = clog2(GATE_IDLE_CYCLES + 1);
  localparam int unsigned TCW            = clog2(TIMEOUT_CYCLES + 1);

  arb_state_e                state_q, state_d;
  logic [IDW-1:0]            ptr_q, ptr_d;
  logic [IDW-1:0]            gidx_q, gidx_d;
  logic [GCW-1:0]            idle_cnt_q, idle_cnt_d;
  logic [TCW-1:0]            tmo_cnt_q, tmo_cnt_d;
  logic                      clk_en_q, clk_en_d;
  logic                      alu_en_q, alu_en_d;
  logic [DATA_IN_WIDTH-1:0]  alu_a_q, alu_a_d;
  logic [DATA_IN_WIDTH-1:0]  alu_b_q, alu_b_d;
  logic [OP_CODE_WIDTH-1:0]  alu_fun_q, alu_fun_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_OUT_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                      rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]        arb_gnt;
  logic [IDW-1:0]            arb_idx;
  logic                      arb_any;
  logic                      grant_ok;

  rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Grants only while idle with the ALU clock already running.
  assign grant_ok  = (state_q == ST_IDLE) && clk_en_q && arb_any;
  assign req_ready = grant_ok ? arb_gnt : '0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    idle_cnt_d  = '0;
    tmo_cnt_d   = tmo_cnt_q;
    clk_en_d    = clk_en_q;
    alu_en_d    = 1'b0;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fun_d   = alu_fun_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          if (!clk_en_q) begin
            clk_en_d = 1'b1;
            state_d  = ST_WAKE;
          end else begin
            alu_a_d   = req_a[32'(arb_idx)*DATA_IN_WIDTH +: DATA_IN_WIDTH];
            alu_b_d   = req_b[32'(arb_idx)*DATA_IN_WIDTH +: DATA_IN_WIDTH];
            alu_fun_d = req_fun[32'(arb_idx)*OP_CODE_WIDTH +: OP_CODE_WIDTH];
            gidx_d    = arb_idx;
            alu_en_d  = 1'b1;
            state_d   = ST_ISSUE;
          end
        end else begin
          // Saturating idle count; gate the ALU clock once it reaches the limit.
          idle_cnt_d = idle_cnt_q;
          if (idle_cnt_q < GCW'(GATE_IDLE_CYCLES)) idle_cnt_d = idle_cnt_q + GCW'(1);
          if (idle_cnt_q >= GCW'(GATE_IDLE_CYCLES - 1)) clk_en_d = 1'b0;
        end
      end
      ST_WAKE: state_d = ST_IDLE;
      ST_ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (alu_out_valid) begin
          rsp_data_d  = alu_out;
          rsp_err_d   = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << gidx_q;
          state_d     = ST_RESP;
        end else if (tmo_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = NUM_REQ'(1) << gidx_q;
          state_d     = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TCW'(1);
        end
      end
      ST_RESP: begin
        ptr_d   = (gidx_q == IDW'(NUM_REQ - 1)) ? '0 : gidx_q + IDW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      idle_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      clk_en_q    <= 1'b0;
      alu_en_q    <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      idle_cnt_q  <= idle_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      clk_en_q    <= clk_en_d;
      alu_en_q    <= alu_en_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fun_q   <= alu_fun_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign alu_en     = alu_en_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_fun    = alu_fun_q;
  assign alu_clk_en = clk_en_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a behavioural registered ALU
// (one-cycle latency, result valid can be suppressed for timeout tests).
module tb_alu_req_arbiter;
  import alu_arb_pkg::*;

  logic        CLK;
  logic        RST;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [15:0] req_fun;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        alu_en;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_fun;
  logic [15:0] alu_out;
  logic        alu_out_valid;
  logic        alu_clk_en;
  logic        alu_dis;

  int checks   = 0;
  int failures = 0;

  alu_req_arbiter dut (
    .CLK           (CLK),
    .RST           (RST),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_fun       (req_fun),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .alu_en        (alu_en),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_fun       (alu_fun),
    .alu_out       (alu_out),
    .alu_out_valid (alu_out_valid),
    .alu_clk_en    (alu_clk_en)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Registered ALU model: result one cycle after alu_en.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_out       <= '0;
      alu_out_valid <= 1'b0;
    end else begin
      alu_out_valid <= alu_en && !alu_dis;
      if (alu_en) begin
        case (alu_fun)
          OP_ADD:  alu_out <= 16'(alu_a) + 16'(alu_b);
          OP_SUB:  alu_out <= 16'(alu_a) - 16'(alu_b);
          OP_MUL:  alu_out <= 16'(alu_a) * 16'(alu_b);
          default: alu_out <= '0;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slice(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] f);
    req_a[i*8 +: 8]   = a;
    req_b[i*8 +: 8]   = b;
    req_fun[i*4 +: 4] = f;
  endtask

  initial begin
    RST       = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_fun   = '0;
    alu_dis   = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_ready",   32'(req_ready), 32'h0);
    chk("rst_rspv",    32'(rsp_valid), 32'h0);
    chk("rst_data",    32'(rsp_data), 32'h0);
    chk("rst_err",     32'(rsp_err), 32'h0);
    chk("rst_alu_en",  32'(alu_en), 32'h0);
    chk("rst_alu_a",   32'(alu_a), 32'h0);
    chk("rst_clk_en",  32'(alu_clk_en), 32'h0);
    RST = 1'b1;

    // Test 1: wake then single ADD from requester 1
    set_slice(1, 8'd20, 8'd5, OP_ADD);
    req_valid = 4'b0010;
    #1;
    chk("t1_no_ready_gated", 32'(req_ready), 32'h0);
    tick();
    chk("t1_clk_en_rise", 32'(alu_clk_en), 32'h1);
    chk("t1_wake_no_ready", 32'(req_ready), 32'h0);
    tick();
    chk("t1_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    chk("t1_alu_en", 32'(alu_en), 32'h1);
    chk("t1_alu_a", 32'(alu_a), 32'd20);
    chk("t1_alu_b", 32'(alu_b), 32'd5);
    chk("t1_alu_fun", 32'(alu_fun), 32'(OP_ADD));
    tick();
    chk("t1_alu_en_drop", 32'(alu_en), 32'h0);
    chk("t1_rspv_early", 32'(rsp_valid), 32'h0);
    tick();
    chk("t1_rspv", 32'(rsp_valid), 32'h2);
    chk("t1_data", 32'(rsp_data), 32'd25);
    chk("t1_err", 32'(rsp_err), 32'h0);
    tick();
    chk("t1_rspv_pulse", 32'(rsp_valid), 32'h0);
    chk("t1_data_hold", 32'(rsp_data), 32'd25);

    // Test 2: reset pointer, then all four requesters continuously
    RST = 1'b0;
    tick();
    RST = 1'b1;
    for (int i = 0; i < 4; i++) set_slice(i, 8'(i + 1), 8'd10, OP_ADD);
    req_valid = 4'hF;
    #1;
    chk("t2_gated", 32'(req_ready), 32'h0);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % 4;
      chk("t2_ready", 32'(req_ready), 32'h1 << g);
      tick();
      chk("t2_alu_a", 32'(alu_a), 32'(g + 1));
      chk("t2_alu_en", 32'(alu_en), 32'h1);
      tick();
      tick();
      chk("t2_rspv", 32'(rsp_valid), 32'h1 << g);
      chk("t2_data", 32'(rsp_data), 32'(g + 11));
      if (k == 4) req_valid = '0;
      tick();
    end

    // Test 3: requester 2 MUL 255*255, operands hold afterwards
    set_slice(2, 8'hFF, 8'hFF, OP_MUL);
    req_valid = 4'b0100;
    #1;
    chk("t3_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    chk("t3_alu_a", 32'(alu_a), 32'hFF);
    tick();
    tick();
    chk("t3_rspv", 32'(rsp_valid), 32'h4);
    chk("t3_data", 32'(rsp_data), 32'hFE01);
    tick();
    chk("t3_alu_a_hold", 32'(alu_a), 32'hFF);
    chk("t3_alu_b_hold", 32'(alu_b), 32'hFF);

    // Test 4: idle gating after 4 cycles, then wake on new request
    tick();
    tick();
    tick();
    chk("t4_clk_en_still", 32'(alu_clk_en), 32'h1);
    tick();
    chk("t4_clk_en_fall", 32'(alu_clk_en), 32'h0);
    chk("t4_alu_a_hold", 32'(alu_a), 32'hFF);
    chk("t4_data_hold", 32'(rsp_data), 32'hFE01);
    set_slice(0, 8'd7, 8'd3, OP_SUB);
    req_valid = 4'b0001;
    #1;
    chk("t4_gated_ready", 32'(req_ready), 32'h0);
    tick();
    chk("t4_clk_en_rise", 32'(alu_clk_en), 32'h1);
    chk("t4_wake_ready", 32'(req_ready), 32'h0);
    tick();
    chk("t4_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    chk("t4_alu_fun", 32'(alu_fun), 32'(OP_SUB));
    tick();
    tick();
    chk("t4_rspv", 32'(rsp_valid), 32'h1);
    chk("t4_data", 32'(rsp_data), 32'd4);
    tick();

    // Test 5: ALU never answers -> timeout error response
    alu_dis = 1'b1;
    set_slice(1, 8'd9, 8'd9, OP_ADD);
    req_valid = 4'b0010;
    #1;
    chk("t5_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    for (int w = 0; w < 8; w++) begin
      tick();
      chk("t5_wait_no_rsp", 32'(rsp_valid), 32'h0);
    end
    tick();
    chk("t5_rspv", 32'(rsp_valid), 32'h2);
    chk("t5_err", 32'(rsp_err), 32'h1);
    chk("t5_data", 32'(rsp_data), 32'h0);
    alu_dis = 1'b0;
    tick();
    chk("t5_rspv_pulse", 32'(rsp_valid), 32'h0);
    chk("t5_err_hold", 32'(rsp_err), 32'h1);

    // Test 6: reset during WAIT aborts the op and clears the pointer
    set_slice(2, 8'd1, 8'd2, OP_ADD);
    req_valid = 4'b0100;
    #1;
    chk("t6_ready_idle", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    tick();
    RST = 1'b0;
    #1;
    chk("t6_rspv", 32'(rsp_valid), 32'h0);
    chk("t6_data", 32'(rsp_data), 32'h0);
    chk("t6_err", 32'(rsp_err), 32'h0);
    chk("t6_alu_a", 32'(alu_a), 32'h0);
    chk("t6_alu_en", 32'(alu_en), 32'h0);
    chk("t6_clk_en", 32'(alu_clk_en), 32'h0);
    tick();
    chk("t6_rspv_in_rst", 32'(rsp_valid), 32'h0);
    RST = 1'b1;
    tick();
    chk("t6_rspv_after_rst", 32'(rsp_valid), 32'h0);
    req_valid = 4'hF;
    #1;
    chk("t6_gated", 32'(req_ready), 32'h0);
    tick();
    tick();
    chk("t6_grant0", 32'(req_ready), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
